// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types, sizes and helpers for the parking slot manager
package parking_pkg;

    localparam int NUM_SLOTS           = 8;
    localparam int SLOT_W              = 3;
    localparam int DEFAULT_GATE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        ALLOC,
        GATE,
        WAIT_CLEAR
    } park_state_t;

    function automatic logic is_onehot(input logic [NUM_SLOTS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [SLOT_W:0] count_ones(input logic [NUM_SLOTS-1:0] v);
        logic [SLOT_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c = c + {{SLOT_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/slot_picker.sv
// rtl/slot_picker.sv - combinational lowest-index free slot encoder
module slot_picker
    import parking_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W-1:0]    index,
    output logic                 none_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        index     = '0;
        none_free = 1'b1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                index     = SLOT_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - entry gate FSM and slot occupancy tracker; PARK_STATS_EN adds total_entries
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [NUM_SLOTS-1:0] exit_location,
    output logic                 entry_ack,
    output logic [SLOT_W-1:0]    entry_token,
    output logic                 gate_open,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W:0]      free_count,
    output logic                 full,
    output logic                 err_exit
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]          total_entries
`endif
);

    park_state_t          state, state_next;
    logic [7:0]           timer, timer_next;
    logic [SLOT_W-1:0]    pick_idx;
    logic                 none_free;
    logic                 alloc;
    logic                 exit_valid;
    logic                 exit_bad;
    logic [NUM_SLOTS-1:0] alloc_mask;
    logic [NUM_SLOTS-1:0] exit_mask;

    slot_picker u_slot_picker (
        .occupancy (occupancy),
        .index     (pick_idx),
        .none_free (none_free)
    );

    assign free_count = (SLOT_W + 1)'(NUM_SLOTS) - count_ones(occupancy);
    assign full       = (free_count == '0);

    // Exits are handled every cycle, independent of the entry FSM.
    assign exit_valid = exit_req && is_onehot(exit_location) && ((exit_location & occupancy) != '0);
    assign exit_bad   = exit_req && !exit_valid;
    assign exit_mask  = exit_valid ? exit_location : '0;
    assign alloc_mask = alloc ? (NUM_SLOTS'(1) << pick_idx) : '0;

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        entry_ack   = 1'b0;
        entry_token = '0;
        gate_open   = 1'b0;
        alloc       = 1'b0;
        case (state)
            IDLE: begin
                if (entry_req && !full) begin
                    state_next = ALLOC;
                end
            end
            ALLOC: begin
                alloc       = !none_free;
                entry_ack   = alloc;
                entry_token = alloc ? pick_idx : '0;
                timer_next  = 8'(GATE_CYCLES);
                state_next  = GATE;
            end
            GATE: begin
                gate_open = 1'b1;
                if (timer <= 8'd1) begin
                    timer_next = '0;
                    state_next = WAIT_CLEAR;
                end else begin
                    timer_next = timer - 8'd1;
                end
            end
            WAIT_CLEAR: begin
                if (!entry_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            occupancy <= '0;
            err_exit  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            occupancy <= (occupancy | alloc_mask) & ~exit_mask;
            err_exit  <= exit_bad;
        end
    end

`ifdef PARK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_entries <= '0;
        end else if (entry_ack) begin
            total_entries <= total_entries + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parking_slot_manager.sv
// tb/tb_parking_slot_manager.sv - directed table, hand sequences and randomized model check of parking_slot_manager
module tb_parking_slot_manager;

    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [7:0] exit_location;
    logic       entry_ack;
    logic [2:0] entry_token;
    logic       gate_open;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       err_exit;
`ifdef PARK_STATS_EN
    logic [15:0] total_entries;
`endif

    int total = 0;
    int bad   = 0;

    parking_slot_manager dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_location (exit_location),
        .entry_ack     (entry_ack),
        .entry_token   (entry_token),
        .gate_open     (gate_open),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full),
        .err_exit      (err_exit)
`ifdef PARK_STATS_EN
        ,
        .total_entries (total_entries)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: lot as an array of flags, gate as a countdown of open cycles.
    int m_occ[8];
    bit m_pend;
    int m_gate;
    bit m_wait;
    bit m_err;
    bit model_on = 1'b0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_occ[i];
        return c;
    endfunction

    function automatic int m_lowfree();
        for (int i = 0; i < 8; i++) if (m_occ[i] == 0) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_occ[i] = 0;
        m_pend = 0; m_gate = 0; m_wait = 0; m_err = 0;
    endtask

    task automatic model_step();
        int  nbits = 0;
        int  idx   = 0;
        bit  valid;
        bit  lot_full = (m_count() == 8);
        for (int i = 0; i < 8; i++) if (exit_location[i]) begin nbits++; idx = i; end
        valid = exit_req && nbits == 1 && m_occ[idx] == 1;
        if (m_pend) begin
            m_occ[m_lowfree()] = 1;
            m_gate = G;
            m_pend = 0;
        end else if (m_gate > 0) begin
            m_gate--;
            if (m_gate == 0) m_wait = 1;
        end else if (m_wait) begin
            if (!entry_req) m_wait = 0;
        end else if (entry_req && !lot_full) begin
            m_pend = 1;
        end
        if (valid) m_occ[idx] = 0;
        m_err = exit_req && !valid;
    endtask

    task automatic model_check();
        logic [7:0]  eocc;
        logic [31:0] exp_v, act_v;
        int          tok;
        for (int i = 0; i < 8; i++) eocc[i] = (m_occ[i] != 0);
        tok   = m_pend ? m_lowfree() : 0;
        exp_v = {13'd0, m_pend, 3'(tok), (m_gate > 0), eocc, 4'(8 - m_count()), (m_count() == 8), m_err};
        act_v = {13'd0, entry_ack, entry_token, gate_open, occupancy, free_count, full, err_exit};
        check("model", act_v, exp_v);
    endtask

    task automatic tick();
        if (model_on) model_step();
        @(posedge clk);
        #1;
        if (model_on) model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_location = 8'h00;
        #1;
        check("rst_occ", occupancy, 8'h00);
        check("rst_free", free_count, 4'd8);
        check("rst_full", full, 1'b0);
        check("rst_ack", entry_ack, 1'b0);
        check("rst_token", entry_token, 3'd0);
        check("rst_gate", gate_open, 1'b0);
        check("rst_err", err_exit, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       req;
        logic       ex;
        logic [7:0] loc;
        logic       e_ack;
        logic       e_gate;
        logic [7:0] e_occ;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int g, acks;

        vecs[0] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b1};

        // Held request: one ack, gate open for exactly G cycles, no re-allocation.
        do_reset();
        entry_req = 1'b1;
        tick();
        check("first_ack", entry_ack, 1'b1);
        check("first_token", entry_token, 3'd0);
        g = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gate_open) g++;
            if (entry_ack) acks++;
        end
        check("gate_cycles", g, G);
        check("held_no_reack", acks, 0);
        check("held_occ", occupancy, 8'h01);
        entry_req = 1'b0;
        tick(); tick();
        entry_req = 1'b1;
        tick();
        check("reack_token", {entry_ack, entry_token}, {1'b1, 3'd1});
        entry_req = 1'b0;

        // Fill the lot in order, then a ninth request is refused.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            entry_req = 1'b1;
            tick();
            check($sformatf("fill_ack%0d", k), {entry_ack, entry_token}, {1'b1, 3'(k)});
            entry_req = 1'b0;
            repeat (20) tick();
        end
        check("fill_occ", occupancy, 8'hFF);
        check("fill_free", free_count, 4'd0);
        check("fill_full", full, 1'b1);
`ifdef PARK_STATS_EN
        check("stats_fill", total_entries, 16'd8);
`endif
        entry_req = 1'b1;
        acks = 0;
        repeat (3) begin
            tick();
            if (entry_ack) acks++;
        end
        check("ninth_no_ack", acks, 0);

        // Free slot 3 while a request waits on a full lot.
        exit_req = 1'b1; exit_location = 8'h08;
        tick();
        exit_req = 1'b0; exit_location = 8'h00;
        check("exit3_occ", occupancy, 8'hF7);
        check("exit3_free", free_count, 4'd1);
        check("exit3_full", full, 1'b0);
        tick();
        check("exit3_realloc", {entry_ack, entry_token}, {1'b1, 3'd3});
        entry_req = 1'b0;
        repeat (20) tick();
`ifdef PARK_STATS_EN
        check("stats_realloc", total_entries, 16'd9);
`endif

        // Rejected exits and a first allocation, cycle by cycle from reset.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            entry_req = vecs[r].req; exit_req = vecs[r].ex; exit_location = vecs[r].loc;
            tick();
            check($sformatf("vec%0d", r), {entry_ack, gate_open, occupancy, err_exit},
                  {vecs[r].e_ack, vecs[r].e_gate, vecs[r].e_occ, vecs[r].e_err});
        end
        entry_req = 1'b0; exit_req = 1'b0; exit_location = 8'h00;
        repeat (20) tick();

        // Exit of slot 0 in the very cycle slot 1 is allocated.
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        repeat (20) tick();
        check("pre_same_occ", occupancy, 8'h01);
        entry_req = 1'b1;
        tick();
        check("same_alloc", {entry_ack, entry_token}, {1'b1, 3'd1});
        entry_req = 1'b0; exit_req = 1'b1; exit_location = 8'h01;
        tick();
        exit_req = 1'b0; exit_location = 8'h00;
        check("same_occ", occupancy, 8'h02);
        check("same_err", err_exit, 1'b0);

        // Reset asserted mid-gate.
        tick();
        check("mid_gate_open", gate_open, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_gate_closed", gate_open, 1'b0);
        check("rst_gate_occ", occupancy, 8'h00);
`ifdef PARK_STATS_EN
        check("rst_stats", total_entries, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        entry_req = 1'b1;
        tick();
        check("post_rst_alloc", {entry_ack, entry_token}, {1'b1, 3'd0});
        entry_req = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        model_on = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0) entry_req = ~entry_req;
            exit_req = ($urandom_range(3) == 0);
            if (!exit_req && $urandom_range(1) == 0)
                exit_location = 8'h00;
            else if ($urandom_range(9) < 7)
                exit_location = 8'h01 << $urandom_range(7);
            else
                exit_location = 8'($urandom);
            tick();
        end
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_slot_manager.md
PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

Interface
REQ-001 Parameter GATE_CYCLES, default 16: cycles the entry gate stays open after an allocation (legal 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 entry_req  input  1  level; a car is waiting at the entry gate.
REQ-005 exit_req  input  1  one-cycle pulse; the exit stage has validated a token.
REQ-006 exit_location  input  8  one-hot slot being vacated (the exit stage's park_location output); sampled only when exit_req=1.
REQ-007 entry_ack  output  1  one-cycle pulse; a slot has been allocated.
REQ-008 entry_token  output  3  index of the allocated slot; valid only while entry_ack=1, else 0.
REQ-009 gate_open  output  1  entry gate open command.
REQ-010 occupancy  output  8  bit i=1 means slot i is occupied.
REQ-011 free_count  output  4  number of free slots, 0..8.
REQ-012 full  output  1  high when free_count==0.
REQ-013 err_exit  output  1  one-cycle pulse on a rejected exit.

Function
REQ-014 FSM states SHALL be IDLE, ALLOC, GATE and WAIT_CLEAR.
REQ-015 IDLE: go to ALLOC when entry_req=1 and full=0; otherwise stay in IDLE.
REQ-016 ALLOC (one cycle): pick the lowest-index free slot; set its occupancy bit; pulse entry_ack with entry_token set to that index; load the gate timer with GATE_CYCLES; go to GATE.
REQ-017 GATE: gate_open=1; the timer decrements each cycle; when the timer reaches 1, go to WAIT_CLEAR, so gate_open is high for exactly GATE_CYCLES cycles.
REQ-018 WAIT_CLEAR: return to IDLE only after entry_req=0, so one request never yields two allocations.
REQ-019 Latency: entry_req rising in IDLE gives entry_ack 1 cycle later and gate_open 2 cycles after entry_req.
REQ-020 Exit is processed independently of FSM state: if exit_req=1, exit_location is exactly one-hot and that slot is occupied, the bit clears on the next edge.
REQ-021 If exit_req=1 and exit_location is zero, not one-hot, or names a free slot, occupancy is unchanged and err_exit pulses on the next cycle.
REQ-022 Simultaneous ALLOC and a valid exit in the same cycle SHALL both take effect (the slots always differ).
REQ-023 A slot freed while full=1 and entry_req=1 SHALL be allocatable: IDLE sees full=0 on the following cycle.
REQ-024 free_count SHALL equal 8 minus the popcount of occupancy, and full SHALL be derived from occupancy, both combinationally.
REQ-025 exit_req with exit_location=0 SHALL never alter state, which covers the exit stage's idle output.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- FSM to IDLE and timer to 0;
- occupancy=0, free_count=8, full=0;
- entry_ack=0, entry_token=0, gate_open=0, err_exit=0.
REQ-027 Reset asserted mid-GATE SHALL close the gate at once; after release, allocation resumes from an empty lot.

Configuration
REQ-028 Macro PARK_STATS_EN defined: add output total_entries (16 bits), which increments on each entry_ack, wraps 0xFFFF->0, and resets to 0.
REQ-029 PARK_STATS_EN undefined: the total_entries port and counter are absent; all other behaviour is identical.

Structure
REQ-030 Shared package parking_pkg SHALL hold:
- the FSM state typedef;
- NUM_SLOTS=8 and SLOT_W=3;
- the default GATE_CYCLES constant.
REQ-031 One sub-module, slot_picker: combinational lowest-free-index encoder taking occupancy and returning index plus a none-free flag.

Verification
REQ-032 Reset, then entry_req=1 held -> entry_ack at cycle 1 with token=0; gate_open high 16 cycles; no second ack until entry_req drops.
REQ-033 Eight entry_req pulses -> tokens 0..7 in order; occupancy=0xFF, free_count=0, full=1; a ninth request gives no ack.
REQ-034 Full lot, exit_req with location=0x08 -> occupancy=0xF7, free_count=1; a waiting entry_req gets token=3.
REQ-035 exit_req with location=0x03, and separately location=0x10 on an empty slot -> err_exit pulse each time, occupancy unchanged.
REQ-036 Exit of slot 0 in the same cycle as ALLOC of slot 1 (occupancy 0x01) -> occupancy=0x02 afterwards.
REQ-037 rst_n low during GATE -> gate_open=0 and occupancy=0 immediately; with PARK_STATS_EN defined, total_entries=0.
